// File: rtl/jesd_tx_pkg.sv
// rtl/jesd_tx_pkg.sv - JESD204B TX link-layer shared encodings
// Purpose: encoder-mux select codes and one-hot link states shared by the link
//          controller, the per-lane ILA generator and the encoder mux.
// Ports:   none (package).
package jesd_tx_pkg;

    localparam logic [2:0] LINK_MUX_DATA = 3'd0;
    localparam logic [2:0] LINK_MUX_K    = 3'd1;
    localparam logic [2:0] LINK_MUX_ILA  = 3'd2;

    localparam logic [3:0] ST_CGS       = 4'b0001;
    localparam logic [3:0] ST_WAIT_LMFC = 4'b0010;
    localparam logic [3:0] ST_ILA       = 4'b0100;
    localparam logic [3:0] ST_DATA      = 4'b1000;

    // Encoder select implied by a link state; anything not ILA/DATA sends K.
    function automatic logic [2:0] link_mux_for(input logic [3:0] st);
        if (st == ST_DATA) begin
            return LINK_MUX_DATA;
        end else if (st == ST_ILA) begin
            return LINK_MUX_ILA;
        end
        return LINK_MUX_K;
    endfunction

endpackage

// File: rtl/jesd_sync_monitor.sv
// rtl/jesd_sync_monitor.sv - SYNC~ classifier for data mode
// Purpose: counts frame ticks with SYNC~ low and classifies the assertion as an
//          error report (short) or a re-initialisation request (long).
// Ports:   clk, rst_n        - clock, async active-low reset
//          active_i          - link in DATA with error reporting enabled
//          frame_clk_i       - frame-boundary tick
//          sync_n_i          - synchronised SYNC~, low = asserted
//          reinit_req_o      - combinational: threshold reached this cycle
//          err_pulse_o       - combinational: short assertion just released
module jesd_sync_monitor
    import jesd_tx_pkg::*;
#(
    parameter int REINIT_FRAMES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic frame_clk_i,
    input  logic sync_n_i,
    output logic reinit_req_o,
    output logic err_pulse_o
);

    localparam int SLW = $clog2(REINIT_FRAMES + 1);
    localparam logic [SLW-1:0] SL_LAST = SLW'(REINIT_FRAMES - 1);

    logic [SLW-1:0] sl_cnt_q, sl_cnt_d;

    // A frame tick that would bring the count to the threshold always wins,
    // even if SYNC~ is released on that same cycle: the frame it closes was
    // spent low, so the receiver asked for re-init, not an error report.
    // The count never passes SL_LAST, so it saturates without wrapping.
    always_comb begin
        sl_cnt_d     = sl_cnt_q;
        reinit_req_o = 1'b0;
        err_pulse_o  = 1'b0;
        if (!active_i) begin
            sl_cnt_d = '0;
        end else if (frame_clk_i && sl_cnt_q == SL_LAST) begin
            reinit_req_o = 1'b1;
            sl_cnt_d     = '0;
        end else if (!sync_n_i) begin
            if (frame_clk_i) begin
                sl_cnt_d = sl_cnt_q + 1'b1;
            end
        end else if (sl_cnt_q != '0) begin
            // Released after at least one frame low; glitches with no frame
            // tick leave the count at zero and are ignored.
            err_pulse_o = 1'b1;
            sl_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_cnt_q <= '0;
        end else begin
            sl_cnt_q <= sl_cnt_d;
        end
    end

endmodule

// File: rtl/tx_link_ctrl.sv
// rtl/tx_link_ctrl.sv - JESD204B transmit link-layer sequencer
// Purpose: sequences CGS (K), LMFC-aligned ILA and user data, and reacts to
//          SYNC~ with re-init or error reporting while in data mode.
// Ports:   clk, rst_n        - clock, async active-low reset
//          frame_clk         - frame-boundary tick
//          lmfc_clk          - LMFC-boundary tick (coincides with frame_clk)
//          i_sync_n          - synchronised SYNC~, low = asserted
//          i_err_reporting   - 1: short SYNC~ in DATA is an error report
//          i_link_en         - 0: hold in CGS
//          o_link_mux        - encoder select (0 data, 1 K, 2 ILA)
//          o_ila_mf_idx      - current ILA multiframe, 0 outside ILA
//          o_link_up         - high in DATA
//          o_err_report      - one-cycle error-report pulse
//          o_state           - one-hot state for debug
module tx_link_ctrl
    import jesd_tx_pkg::*;
#(
    parameter int K_MIN_FRAMES    = 4,
    parameter int ILA_MULTIFRAMES = 4,
    parameter int REINIT_FRAMES   = 5,
    localparam int MFW = (ILA_MULTIFRAMES > 1) ? $clog2(ILA_MULTIFRAMES) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_clk,
    input  logic           lmfc_clk,
    input  logic           i_sync_n,
    input  logic           i_err_reporting,
    input  logic           i_link_en,
    output logic [2:0]     o_link_mux,
    output logic [MFW-1:0] o_ila_mf_idx,
    output logic           o_link_up,
    output logic           o_err_report,
    output logic [3:0]     o_state
);

    localparam int KW = $clog2(K_MIN_FRAMES + 1);
    localparam logic [KW-1:0]  K_LAST  = KW'(K_MIN_FRAMES);
    localparam logic [MFW-1:0] MF_LAST = MFW'(ILA_MULTIFRAMES - 1);

    logic [3:0]     state_q, state_d;
    logic [KW-1:0]  k_cnt_q, k_cnt_d;
    logic [MFW-1:0] mf_cnt_q, mf_cnt_d;
    logic [2:0]     link_mux_q;
    logic           link_up_q;
    logic           err_report_q;

    logic           mon_active;
    logic           reinit_req;
    logic           err_pulse;

    assign mon_active = (state_q == ST_DATA) && i_err_reporting && i_link_en;

    jesd_sync_monitor #(
        .REINIT_FRAMES (REINIT_FRAMES)
    ) u_sync_monitor (
        .clk          (clk),
        .rst_n        (rst_n),
        .active_i     (mon_active),
        .frame_clk_i  (frame_clk),
        .sync_n_i     (i_sync_n),
        .reinit_req_o (reinit_req),
        .err_pulse_o  (err_pulse)
    );

    always_comb begin
        state_d = state_q;
        if (!i_link_en) begin
            state_d = ST_CGS;
        end else begin
            case (state_q)
                ST_CGS: begin
                    if (i_sync_n && k_cnt_q == K_LAST) begin
                        state_d = ST_WAIT_LMFC;
                    end
                end
                ST_WAIT_LMFC: begin
                    if (!i_sync_n) begin
                        state_d = ST_CGS;
                    end else if (lmfc_clk) begin
                        state_d = ST_ILA;
                    end
                end
                ST_ILA: begin
                    // SYNC~ is checked first so a fall on the final LMFC tick
                    // restarts CGS instead of entering DATA.
                    if (!i_sync_n) begin
                        state_d = ST_CGS;
                    end else if (lmfc_clk && mf_cnt_q == MF_LAST) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_err_reporting ? reinit_req : !i_sync_n) begin
                        state_d = ST_CGS;
                    end
                end
                default: state_d = ST_CGS;
            endcase
        end
    end

    // K frames only accumulate while sitting in CGS with SYNC~ released; any
    // other condition (including being outside CGS) keeps the count at zero,
    // which also provides the clear on re-entry.
    always_comb begin
        k_cnt_d = '0;
        if (state_q == ST_CGS && i_link_en && i_sync_n) begin
            k_cnt_d = k_cnt_q;
            if (frame_clk && k_cnt_q != K_LAST) begin
                k_cnt_d = k_cnt_q + 1'b1;
            end
        end
    end

    // The multiframe index is zero whenever the next state is not ILA, so the
    // register doubles as the registered o_ila_mf_idx output. The LMFC tick
    // that enters ILA is not counted: it starts multiframe 0.
    always_comb begin
        mf_cnt_d = '0;
        if (state_d == ST_ILA) begin
            mf_cnt_d = mf_cnt_q;
            if (state_q == ST_ILA && lmfc_clk && mf_cnt_q != MF_LAST) begin
                mf_cnt_d = mf_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CGS;
            k_cnt_q      <= '0;
            mf_cnt_q     <= '0;
            link_mux_q   <= LINK_MUX_K;
            link_up_q    <= 1'b0;
            err_report_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_cnt_q      <= k_cnt_d;
            mf_cnt_q     <= mf_cnt_d;
            link_mux_q   <= link_mux_for(state_d);
            link_up_q    <= (state_d == ST_DATA);
            err_report_q <= err_pulse && (state_d == ST_DATA);
        end
    end

    assign o_link_mux   = link_mux_q;
    assign o_ila_mf_idx = mf_cnt_q;
    assign o_link_up    = link_up_q;
    assign o_err_report = err_report_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// tb/tb_tx_link_ctrl.sv - self-checking bench for tx_link_ctrl
module tb_tx_link_ctrl;

    localparam int K  = 4;
    localparam int N  = 4;
    localparam int R  = 5;
    localparam int FP = 4;
    localparam int LP = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_clk = 1'b0;
    logic       lmfc_clk = 1'b0;
    logic       i_sync_n = 1'b0;
    logic       i_err_reporting = 1'b1;
    logic       i_link_en = 1'b1;
    logic [2:0] o_link_mux;
    logic [1:0] o_ila_mf_idx;
    logic       o_link_up;
    logic       o_err_report;
    logic [3:0] o_state;

    int checks = 0;
    int failures = 0;
    int ph = 0;
    int err_cnt = 0;
    int mux_nz = 0;

    // Reference: phase 0 CGS, 1 WAIT_LMFC, 2 ILA, 3 DATA; plain integer counters.
    int m_phase, m_k, m_mf, m_sl;
    int e_mux, e_idx, e_up, e_err, e_state;

    always #5 clk = ~clk;

    tx_link_ctrl #(
        .K_MIN_FRAMES    (K),
        .ILA_MULTIFRAMES (N),
        .REINIT_FRAMES   (R)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_clk       (frame_clk),
        .lmfc_clk        (lmfc_clk),
        .i_sync_n        (i_sync_n),
        .i_err_reporting (i_err_reporting),
        .i_link_en       (i_link_en),
        .o_link_mux      (o_link_mux),
        .o_ila_mf_idx    (o_ila_mf_idx),
        .o_link_up       (o_link_up),
        .o_err_report    (o_err_report),
        .o_state         (o_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_mf = 0; m_sl = 0;
        e_mux = 1; e_idx = 0; e_up = 0; e_err = 0; e_state = 1;
    endtask

    task automatic model_step();
        int nxt;
        int err;
        nxt = m_phase;
        err = 0;
        if (!i_link_en) nxt = 0;
        else if (m_phase == 0) begin
            if (i_sync_n && m_k == K) nxt = 1;
        end else if (m_phase == 1) begin
            if (!i_sync_n) nxt = 0;
            else if (lmfc_clk) nxt = 2;
        end else if (m_phase == 2) begin
            if (!i_sync_n) nxt = 0;
            else if (lmfc_clk && m_mf == N - 1) nxt = 3;
        end else if (!i_err_reporting) begin
            if (!i_sync_n) nxt = 0;
        end else if (frame_clk && m_sl == R - 1) nxt = 0;
        else if (i_sync_n && m_sl > 0) err = 1;

        if (m_phase == 0 && i_link_en && i_sync_n) begin
            if (frame_clk && m_k < K) m_k = m_k + 1;
        end else m_k = 0;

        if (nxt == 2) begin
            if (m_phase == 2 && lmfc_clk) m_mf = m_mf + 1;
        end else m_mf = 0;

        if (nxt == 3 && m_phase == 3 && i_err_reporting && !i_sync_n) begin
            if (frame_clk) m_sl = m_sl + 1;
        end else m_sl = 0;

        m_phase = nxt;
        e_state = 1 << nxt;
        e_mux   = (nxt == 3) ? 0 : (nxt == 2) ? 2 : 1;
        e_idx   = m_mf;
        e_up    = (nxt == 3) ? 1 : 0;
        e_err   = err;
    endtask

    task automatic check_outputs();
        check("link_mux", 32'(o_link_mux), e_mux);
        check("ila_mf_idx", 32'(o_ila_mf_idx), e_idx);
        check("link_up", 32'(o_link_up), e_up);
        check("err_report", 32'(o_err_report), e_err);
        check("state", 32'(o_state), e_state);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mux"}, 32'(o_link_mux), 1);
        check({tag, "_idx"}, 32'(o_ila_mf_idx), 0);
        check({tag, "_up"}, 32'(o_link_up), 0);
        check({tag, "_err"}, 32'(o_err_report), 0);
        check({tag, "_state"}, 32'(o_state), 1);
    endtask

    task automatic cyc();
        frame_clk = (ph % FP == 0);
        lmfc_clk  = (ph % LP == 0);
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (o_err_report) err_cnt++;
        if (o_link_mux != 3'd0) mux_nz++;
        ph++;
    endtask

    task automatic wait_state(input logic [3:0] st, input string tag);
        int n = 0;
        while (o_state !== st && n < 300) begin
            cyc();
            n++;
        end
        check(tag, 32'(o_state), 32'(st));
    endtask

    task automatic wait_ila_idx(input logic [1:0] idx, input string tag);
        int n = 0;
        while (!(o_state === 4'b0100 && o_ila_mf_idx === idx) && n < 300) begin
            cyc();
            n++;
        end
        check(tag, {o_state, o_ila_mf_idx}, {4'b0100, idx});
    endtask

    task automatic sync_low_ticks(input int n);
        int t = 0;
        int g = 0;
        i_sync_n = 1'b0;
        while (t < n && g < 200) begin
            cyc();
            if (frame_clk) t++;
            g++;
        end
        check("sync_low_ticks", t, n);
    endtask

    initial begin
        int mask;
        int ila_cyc;
        int n;
        int e0;
        int m0;
        int dur;

        ph = $urandom_range(0, LP - 1);
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Bring-up: SYNC~ low for 10 frames, then release.
        sync_low_ticks(10);
        i_sync_n = 1'b1;
        mask = 0; ila_cyc = 0; n = 0;
        while (o_state !== 4'b1000 && n < 300) begin
            cyc();
            n++;
            if (o_state === 4'b0100) begin
                mask = mask | (1 << o_ila_mf_idx);
                ila_cyc++;
            end
        end
        check("ila_idx_steps", mask, 15);
        check("ila_length", ila_cyc, N * LP);
        check("link_up_after_ila", 32'(o_link_up), 1);

        // Short SYNC~ in DATA: one error report, stays in data.
        e0 = err_cnt; m0 = mux_nz;
        sync_low_ticks(3);
        i_sync_n = 1'b1;
        repeat (10) cyc();
        check("err_pulse_count", err_cnt - e0, 1);
        check("mux_stays_data", mux_nz - m0, 0);

        // Brief glitch, possibly without a frame tick.
        dur = $urandom_range(1, 3);
        i_sync_n = 1'b0;
        repeat (dur) cyc();
        i_sync_n = 1'b1;
        repeat (8) cyc();

        // Long SYNC~: re-init after the fifth tick, no error report.
        e0 = err_cnt;
        sync_low_ticks(5);
        check("reinit_mux", 32'(o_link_mux), 1);
        i_sync_n = 1'b1;
        repeat (10) cyc();
        check("reinit_no_err", err_cnt - e0, 0);
        wait_state(4'b1000, "resync_up");

        // Threshold tick on the same cycle SYNC~ rises: re-init, no pulse.
        e0 = err_cnt;
        sync_low_ticks(4);
        while (ph % FP != 0) cyc();
        i_sync_n = 1'b1;
        cyc();
        check("sim_rise_reinit", 32'(o_state), 1);
        check("sim_rise_no_err", err_cnt - e0, 0);
        wait_state(4'b1000, "sim_rise_up");

        // Error reporting off: any low forces CGS next cycle.
        i_err_reporting = 1'b0;
        i_sync_n = 1'b0;
        cyc();
        check("noerr_cgs", 32'(o_state), 1);
        i_sync_n = 1'b1;
        wait_state(4'b1000, "noerr_up");
        i_err_reporting = 1'b1;

        // Link disable from DATA, then SYNC~ during ILA multiframe 2.
        i_link_en = 1'b0;
        cyc();
        check("link_en_cgs", 32'(o_state), 1);
        i_link_en = 1'b1;
        wait_ila_idx(2'd2, "reach_ila_mf2");
        i_sync_n = 1'b0;
        cyc();
        check("ila_sync_cgs", 32'(o_state), 1);
        check("ila_sync_idx", 32'(o_ila_mf_idx), 0);
        i_sync_n = 1'b1;
        wait_state(4'b0100, "ila_restart");
        check("ila_restart_idx", 32'(o_ila_mf_idx), 0);
        wait_state(4'b1000, "ila_restart_up");

        // SYNC~ falls on the final ILA LMFC tick: CGS, not DATA.
        i_link_en = 1'b0;
        cyc();
        i_link_en = 1'b1;
        wait_ila_idx(2'd3, "reach_ila_mf3");
        while (ph % LP != 0) cyc();
        i_sync_n = 1'b0;
        cyc();
        check("ila_final_sync", 32'(o_state), 1);
        i_sync_n = 1'b1;
        wait_state(4'b1000, "ila_final_up");

        // Randomised SYNC~ assertions in DATA.
        for (int i = 0; i < 8; i++) begin
            i_err_reporting = 1'($urandom_range(0, 1));
            dur = $urandom_range(1, 28);
            i_sync_n = 1'b0;
            repeat (dur) cyc();
            i_sync_n = 1'b1;
            repeat ($urandom_range(1, 5)) cyc();
            wait_state(4'b1000, "random_up");
        end
        i_err_reporting = 1'b1;

        // Link disable in DATA, then async reset mid-ILA.
        i_link_en = 1'b0;
        cyc();
        check("disable_state", 32'(o_state), 1);
        check("disable_up", 32'(o_link_up), 0);
        i_link_en = 1'b1;
        wait_ila_idx(2'd1, "reach_ila_mf1");
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        model_reset();
        #1 rst_n = 1'b1;
        wait_state(4'b1000, "post_reset_up");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
